// File: rtl/alu_bus_sequencer.sv
// Sequences the shared tri-state ALU result bus: one driver enable per operation, then a turnaround cycle.
// Build option ALU_BUS_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and reports an error result instead.
module alu_bus_sequencer #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [SEL_W-1:0]   op_src,
    input  logic [NUM_SRC-1:0] src_done,
    output logic [NUM_SRC-1:0] bus_en,
    input  logic [WIDTH-1:0]   bus,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_zero,
    output logic               res_neg,
    output logic               res_err,
    output logic [1:0]         dbg_state
);
    localparam int NSEL = 1 << SEL_W;

    typedef enum logic [1:0] {IDLE, WAIT, DRIVE, TURN} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_SRC-1:0] bus_en_q, bus_en_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_zero_q, res_zero_d;
    logic               res_neg_q, res_neg_d;
    logic               res_err_q, res_err_d;
    logic [NSEL-1:0]    src_ok_mask;
    logic               accept;
    logic               src_ok;
    logic               sel_done;
    logic               timed_out;

`ifdef ALU_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is zero in every non-WAIT cycle, so it is already clear on WAIT entry.
    always_comb begin
        cnt_d     = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
        timed_out = (cnt_q == CNT_W'(TIMEOUT - 1)) && !sel_done;
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NSEL; i++) begin
            src_ok_mask[i] = (i < NUM_SRC);
        end
    end

    assign op_ready = rst_n && (state_q == IDLE) && !res_valid_q;
    assign accept   = op_valid && op_ready;
    assign src_ok   = src_ok_mask[op_src];
    assign sel_done = src_done[sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            bus_en_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_neg_q   <= 1'b0;
            res_err_q   <= 1'b0;
`ifdef ALU_BUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            bus_en_q    <= bus_en_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_neg_q   <= res_neg_d;
            res_err_q   <= res_err_d;
`ifdef ALU_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = src_ok ? WAIT : TURN;
            WAIT: begin
                if (sel_done)       state_d = DRIVE;
                else if (timed_out) state_d = TURN;
            end
            DRIVE:   state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Enable is registered and only set on the WAIT->DRIVE edge, so it is low in TURN.
    always_comb begin
        sel_d       = sel_q;
        bus_en_d    = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_neg_d   = res_neg_q;
        res_err_d   = res_err_q;
        if (res_valid_q && res_ready) res_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_d = op_src;
                    if (!src_ok) begin
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                        res_data_d  = '0;
                        res_zero_d  = 1'b1;
                        res_neg_d   = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (sel_done) begin
                    bus_en_d = NUM_SRC'(1) << sel_q;
                end else if (timed_out) begin
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    res_data_d  = '0;
                    res_zero_d  = 1'b1;
                    res_neg_d   = 1'b0;
                end
            end
            DRIVE: begin
                res_valid_d = 1'b1;
                res_data_d  = bus;
                res_zero_d  = (bus == '0);
                res_neg_d   = bus[WIDTH-1];
                res_err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus_en    = bus_en_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_neg   = res_neg_q;
    assign res_err   = res_err_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Bench for alu_bus_sequencer: timeline model checked every cycle plus directed literal checks.
module tb_alu_bus_sequencer;
    localparam int W  = 32;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [SW-1:0] op_src = '0;
    logic [NS-1:0] src_done = '0;
    logic [NS-1:0] bus_en;
    logic [W-1:0]  bus = '0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [W-1:0]  res_data;
    logic          res_zero, res_neg, res_err;
    logic [1:0]    dbg_state;

    logic          op_valid3 = 1'b0;
    logic          op_ready3;
    logic [SW-1:0] op_src3 = '0;
    logic [2:0]    src_done3 = '0;
    logic [2:0]    bus_en3;
    logic [W-1:0]  bus3 = 32'hDEAD_BEEF;
    logic          res_valid3;
    logic          res_ready3 = 1'b0;
    logic [W-1:0]  res_data3;
    logic          res_zero3, res_neg3, res_err3;
    logic [1:0]    dbg_state3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_bus_sequencer #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_src(op_src),
        .src_done(src_done), .bus_en(bus_en), .bus(bus), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero), .res_neg(res_neg),
        .res_err(res_err), .dbg_state(dbg_state)
    );

    alu_bus_sequencer #(.WIDTH(W), .NUM_SRC(3), .SEL_W(SW), .TIMEOUT(TO)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid3), .op_ready(op_ready3), .op_src(op_src3),
        .src_done(src_done3), .bus_en(bus_en3), .bus(bus3), .res_valid(res_valid3),
        .res_ready(res_ready3), .res_data(res_data3), .res_zero(res_zero3), .res_neg(res_neg3),
        .res_err(res_err3), .dbg_state(dbg_state3)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: an accepted op waits until its done bit is seen, drives the next cycle,
    // then the result appears and one turnaround cycle passes before the next accept.
    logic          m_busy = 1'b0, m_drive_next = 1'b0, m_turn = 1'b0, m_rv = 1'b0, m_err = 1'b0;
    logic [SW-1:0] m_src = '0;
    logic [W-1:0]  m_data = '0;
    int            m_wcnt = 0;
    logic [NS-1:0] prev_en = '0;
    logic [NS-1:0] exp_en;
    logic          exp_rdy, nb, nd, nt, nrv;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_bus_en", bus_en, '0);
            check("rst_res_valid", res_valid, 1'b0);
            check("rst_op_ready", op_ready, 1'b0);
            m_busy = 0; m_drive_next = 0; m_turn = 0; m_rv = 0; m_err = 0;
            m_data = '0; m_wcnt = 0; prev_en = '0;
        end else begin
            exp_en  = m_drive_next ? (NS'(1) << m_src) : '0;
            exp_rdy = !m_busy && !m_turn && !m_rv;
            check("bus_en", bus_en, exp_en);
            check("op_ready", op_ready, exp_rdy);
            check("res_valid", res_valid, m_rv);
            check("onehot", $countones(bus_en) <= 1, 1'b1);
            check("turnaround", (prev_en != '0) && (bus_en != '0), 1'b0);
            if (m_rv) begin
                check("res_data", res_data, m_data);
                check("res_zero", res_zero, m_data == '0);
                check("res_neg", res_neg, m_data[W-1]);
                check("res_err", res_err, m_err);
            end
            nb = m_busy; nd = 1'b0; nt = 1'b0; nrv = m_rv;
            if (m_rv && res_ready) nrv = 1'b0;
            if (m_drive_next) begin
                nb = 1'b0; nt = 1'b1; nrv = 1'b1; m_data = bus; m_err = 1'b0;
            end else if (m_busy) begin
                m_wcnt++;
                if (src_done[m_src]) nd = 1'b1;
`ifdef ALU_BUS_TIMEOUT_EN
                else if (m_wcnt == TO) begin
                    nb = 1'b0; nt = 1'b1; nrv = 1'b1; m_data = '0; m_err = 1'b1;
                end
`endif
            end else if (exp_rdy && op_valid) begin
                nb = 1'b1; m_src = op_src; m_wcnt = 0;
            end
            m_busy = nb; m_drive_next = nd; m_turn = nt; m_rv = nrv;
            prev_en = bus_en;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds op_valid until accepted; returns 1 time unit after the accepting edge.
    task automatic accept_op(input logic [SW-1:0] src);
        bit got = 1'b0;
        op_valid = 1'b1;
        op_src   = src;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = op_ready;
        end
        if (!got) begin
            check("accept_timeout", 1'b0, 1'b1);
            op_valid = 1'b0;
        end else begin
            step();
            op_valid = 1'b0;
        end
    endtask

    initial begin
        #2;
        check("rst_res_data", res_data, '0);
        check("rst_res_flags", {res_zero, res_neg, res_err}, 3'b000);
        check("rst_op_ready_lit", op_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Invalid source on a 3-source bus, result held until consumed.
        op_valid3 = 1'b1; op_src3 = 2'd3;
        @(negedge clk); check("t4_ready", op_ready3, 1'b1);
        step(); op_valid3 = 1'b0;
        @(negedge clk);
        check("t4_valid", res_valid3, 1'b1);
        check("t4_err", res_err3, 1'b1);
        check("t4_data", res_data3, '0);
        check("t4_zero_neg", {res_zero3, res_neg3}, 2'b10);
        check("t4_en_turn", bus_en3, 3'b000);
        check("t4_ready_turn", op_ready3, 1'b0);
        step();
        @(negedge clk);
        check("t4_ready_held", op_ready3, 1'b0);
        check("t4_en_idle", bus_en3, 3'b000);
        step(); res_ready3 = 1'b1;
        @(negedge clk); check("t4_valid_before", res_valid3, 1'b1);
        step();
        @(negedge clk);
        check("t4_valid_clear", res_valid3, 1'b0);
        check("t4_ready_back", op_ready3, 1'b1);
        step();

        // Done already high: WAIT, DRIVE, then result in TURN.
        src_done = 4'b0100; bus = 32'h8000_0001;
        accept_op(2'd2);
        @(negedge clk); check("t1_wait_en", bus_en, 4'b0000);
        @(negedge clk); check("t1_drive_en", bus_en, 4'b0100);
        @(negedge clk);
        check("t1_turn_en", bus_en, 4'b0000);
        check("t1_valid", res_valid, 1'b1);
        check("t1_data", res_data, 32'h8000_0001);
        check("t1_flags", {res_zero, res_neg, res_err}, 3'b010);
        step(); src_done = '0; bus = 32'h1111_1111;

        // Done rises five cycles after acceptance with a zero result.
        accept_op(2'd1);
        repeat (4) step();
        src_done = 4'b0010; bus = 32'h0;
        @(negedge clk); check("t2_wait_en", bus_en, 4'b0000);
        @(negedge clk); check("t2_drive_en", bus_en, 4'b0010);
        @(negedge clk);
        check("t2_turn_en", bus_en, 4'b0000);
        check("t2_valid", res_valid, 1'b1);
        check("t2_data", res_data, 32'h0);
        check("t2_flags", {res_zero, res_neg, res_err}, 3'b100);
        step(); src_done = '0;

        // Back-to-back ops to sources 0 and 3.
        src_done = 4'b1001; bus = 32'h5A5A_0F0F;
        accept_op(2'd0);
        accept_op(2'd3);
        @(negedge clk);
        @(negedge clk); check("t3_drive3_en", bus_en, 4'b1000);
        @(negedge clk);
        check("t3_valid", res_valid, 1'b1);
        check("t3_data", res_data, 32'h5A5A_0F0F);
        step(); src_done = '0;

        // Result held with res_ready low blocks new operations.
        res_ready = 1'b0; src_done = 4'b0100; bus = 32'h0000_1234;
        accept_op(2'd2);
        @(negedge clk);
        @(negedge clk);
        step();
        op_valid = 1'b1; op_src = 2'd1; src_done = 4'b0000;
        repeat (4) begin
            @(negedge clk);
            check("t5_ready_low", op_ready, 1'b0);
            check("t5_valid_held", res_valid, 1'b1);
            check("t5_data_held", res_data, 32'h0000_1234);
        end
        step(); op_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk); check("t5_valid_before", res_valid, 1'b1);
        step();
        @(negedge clk);
        check("t5_valid_clear", res_valid, 1'b0);
        check("t5_ready_back", op_ready, 1'b1);

        // Asynchronous reset in the middle of DRIVE.
        src_done = 4'b0001; bus = 32'hFFFF_FFFF;
        accept_op(2'd0);
        @(posedge clk);
        #3;
        check("t6_pre_en", bus_en, 4'b0001);
        rst_n = 1'b0;
        #1;
        check("t6_async_en", bus_en, 4'b0000);
        check("t6_async_valid", res_valid, 1'b0);
        check("t6_async_ready", op_ready, 1'b0);
        @(negedge clk);
        step(); rst_n = 1'b1; src_done = '0;
        step();

`ifdef ALU_BUS_TIMEOUT_EN
        // Source never finishes: error result after TIMEOUT WAIT cycles.
        accept_op(2'd0);
        repeat (TO) begin
            @(negedge clk);
            check("t7_wait_en", bus_en, 4'b0000);
            check("t7_wait_valid", res_valid, 1'b0);
        end
        @(negedge clk);
        check("t7_valid", res_valid, 1'b1);
        check("t7_err", res_err, 1'b1);
        check("t7_data", res_data, 32'h0);
        check("t7_zero", res_zero, 1'b1);
        step();
`endif

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
